stream_mux4: RTL and testbench

STREAM_MUX4 -- requirements
Module: stream_mux4

---
 rtl/stream_mux4.sv | 153 +++++++++++++++
 tb/tb_stream_mux4.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux4.sv
// Four-channel valid/ready stream mux with round-robin arbitration and a registered output stage.
// Optional packet locking is enabled by defining STREAM_MUX4_LOCK_EN.
module stream_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] din,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef STREAM_MUX4_LOCK_EN
    input  logic [3:0]         in_last,
    output logic               out_last,
`endif
    output logic [1:0]         sel
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [WIDTH-1:0]   ch_s [4];
    logic               load_s;
    logic               found_s;
    logic [1:0]         gnt_s;
    logic               accept_s;
    logic [1:0]         idx_s;
`ifdef STREAM_MUX4_LOCK_EN
    logic               lock_q, lock_d;
    logic               last_q, last_d;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_split
        assign ch_s[i] = din[i*WIDTH +: WIDTH];
    end

    assign load_s    = (state_q == ST_EMPTY) || out_ready;
    assign out_valid = (state_q == ST_FULL);
    assign dout      = dout_q;
    assign sel       = sel_q;
`ifdef STREAM_MUX4_LOCK_EN
    assign out_last  = last_q;
`endif

    // Round-robin search from ptr; a locked packet only considers its own channel (sel_q).
    always_comb begin
        found_s = 1'b0;
        gnt_s   = ptr_q;
        idx_s   = ptr_q;
`ifdef STREAM_MUX4_LOCK_EN
        if (lock_q) begin
            found_s = in_valid[sel_q];
            gnt_s   = sel_q;
        end else begin
`endif
            for (int k = 0; k < 4; k++) begin
                idx_s = ptr_q + 2'(k);
                if (!found_s && in_valid[idx_s]) begin
                    found_s = 1'b1;
                    gnt_s   = idx_s;
                end else begin
                    found_s = found_s;
                end
            end
`ifdef STREAM_MUX4_LOCK_EN
        end
`endif
    end

    // One-hot ready for the granted channel; forced low during reset.
    always_comb begin
        accept_s = load_s && found_s && !rst;
        in_ready = 4'b0000;
        if (accept_s) begin
            in_ready[gnt_s] = 1'b1;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Output FSM next state: accept (possibly drain+reload), drain to EMPTY, or hold.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef STREAM_MUX4_LOCK_EN
        lock_d  = lock_q;
        last_d  = last_q;
`endif
        if (accept_s) begin
            state_d = ST_FULL;
            dout_d  = ch_s[gnt_s];
            sel_d   = gnt_s;
`ifdef STREAM_MUX4_LOCK_EN
            last_d  = in_last[gnt_s];
            if (in_last[gnt_s]) begin
                lock_d = 1'b0;
                ptr_d  = gnt_s + 2'd1;
            end else begin
                lock_d = 1'b1;
                ptr_d  = ptr_q;
            end
`else
            ptr_d   = gnt_s + 2'd1;
`endif
        end else begin
            case (state_q)
                ST_FULL: begin
                    if (out_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                ST_EMPTY: state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            dout_q  <= {WIDTH{1'b0}};
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef STREAM_MUX4_LOCK_EN
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef STREAM_MUX4_LOCK_EN
            lock_q  <= lock_d;
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_mux4.sv
// Directed self-checking bench for stream_mux4 (lock scenario runs when STREAM_MUX4_LOCK_EN is defined).
module tb_stream_mux4;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  dout;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  sel;
`ifdef STREAM_MUX4_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    stream_mux4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STREAM_MUX4_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [7:0] v);
        din[i*8 +: 8] = v;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [1:0] s, input logic [7:0] d);
        check_val({tag, "_ov"}, 32'(out_valid), 32'(ov));
        check_val({tag, "_sel"}, 32'(sel), 32'(s));
        check_val({tag, "_dout"}, 32'(dout), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        din = 32'h0;
        in_valid = 4'b1111;
        out_ready = 1'b1;
`ifdef STREAM_MUX4_LOCK_EN
        in_last = 4'b1111;
`endif
        tick();
        check_out("reset", 1'b0, 2'd0, 8'h00);
        check_val("reset_in_ready", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        tick();
        rst = 1'b0;

        // Round robin over four always-valid channels.
        for (int i = 0; i < 4; i++) set_ch(i, 8'h10 + 8'(i));
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val($sformatf("rr_in_ready%0d", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            check_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 8'h10 + 8'(k % 4));
        end
        in_valid = 4'b0000;
        tick();
        check_val("rr_drain_ov", 32'(out_valid), 32'h0);

        // Single beat on channel 2.
        set_ch(2, 8'hA5);
        in_valid = 4'b0100;
        #1;
        check_val("single_in_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("single", 1'b1, 2'd2, 8'hA5);
        in_valid = 4'b0000;
        #1;
        check_val("single_idle_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("single_drain", 1'b0, 2'd2, 8'hA5);

        // Backpressure while FULL.
        set_ch(0, 8'h3C);
        in_valid = 4'b0001;
        out_ready = 1'b0;
        #1;
        check_val("bp_load_ready", 32'(in_ready), 32'h1);
        tick();
        check_out("bp_load", 1'b1, 2'd0, 8'h3C);
        set_ch(0, 8'h77);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("bp_ready%0d", k), 32'(in_ready), 32'h0);
            tick();
            check_out($sformatf("bp_hold%0d", k), 1'b1, 2'd0, 8'h3C);
        end
        in_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
        check_out("bp_consumed", 1'b0, 2'd0, 8'h3C);

        // Reset mid-operation while FULL.
        set_ch(1, 8'h21);
        in_valid = 4'b0010;
        tick();
        check_out("rst_pre", 1'b1, 2'd1, 8'h21);
        set_ch(3, 8'hD3);
        in_valid = 4'b1000;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_out("rst_async", 1'b0, 2'd0, 8'h00);
        check_val("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("post_rst_ready", 32'(in_ready), 32'h8);
        tick();
        check_out("post_rst", 1'b1, 2'd3, 8'hD3);
        in_valid = 4'b0000;
        tick();

        // Pointer returns to channel 0 after reset.
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        in_valid = 4'b1010;
        #1;
        check_val("ptr_rst_ready", 32'(in_ready), 32'h2);
        tick();
        check_out("ptr_rst", 1'b1, 2'd1, 8'h21);
        in_valid = 4'b0000;
        tick();

        // Lone channel streaming without bubbles.
        in_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            set_ch(0, 8'h60 + 8'(k));
            #1;
            check_val($sformatf("lone_ready%0d", k), 32'(in_ready), 32'h1);
            tick();
            check_out($sformatf("lone%0d", k), 1'b1, 2'd0, 8'h60 + 8'(k));
        end
        in_valid = 4'b0000;
        tick();
        check_val("lone_drain_ov", 32'(out_valid), 32'h0);

`ifdef STREAM_MUX4_LOCK_EN
        // Packet lock on channel 1 (ptr is 1 here) while channels 0 and 2 compete.
        set_ch(0, 8'hA0);
        set_ch(2, 8'hC2);
        in_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            set_ch(1, 8'hB1 + 8'(k));
            in_last = (k == 2) ? 4'b0111 : 4'b0101;
            #1;
            check_val($sformatf("lock_ready%0d", k), 32'(in_ready), 32'h2);
            tick();
            check_out($sformatf("lock%0d", k), 1'b1, 2'd1, 8'hB1 + 8'(k));
            check_val($sformatf("lock_last%0d", k), 32'(out_last), (k == 2) ? 32'h1 : 32'h0);
        end
        #1;
        check_val("unlock_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("unlock", 1'b1, 2'd2, 8'hC2);
        in_valid = 4'b0000;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
